// File: rtl/mac_tx_framegen.sv
// XGMII transmit frame generator: small lane-word FIFO feeding a registered
// per-lane source mux (error / preamble header / buffered data / idle).

module mac_tx_lane #(
    parameter int              W_BYTE        = 8,
    parameter int              N_CHANNELS    = 4,
    parameter int              MAC_HDR_CNT   = 2,
    parameter int              W_MAC_HDR_CNT = 2,
    parameter int              LANE          = 0,
    parameter logic [W_BYTE-1:0] SYM_IDLE    = 8'h07,
    parameter logic [W_BYTE-1:0] SYM_ERROR   = 8'hFE
) (
    input  logic                     sel_err,
    input  logic                     sel_hdr,
    input  logic                     sel_data,
    input  logic [W_MAC_HDR_CNT-1:0] hdr_id,
    input  logic                     head_ctrl,
    input  logic [W_BYTE-1:0]        head_byte,
    output logic [W_BYTE-1:0]        nxt_byte,
    output logic                     nxt_ctrl
);
    localparam int K_LAST = N_CHANNELS * MAC_HDR_CNT - 1;

    int k;

    always_comb begin
        k        = int'(hdr_id) * N_CHANNELS + LANE;
        nxt_byte = SYM_IDLE;
        nxt_ctrl = 1'b1;
        if (sel_err) begin
            nxt_byte = SYM_ERROR;
            nxt_ctrl = 1'b1;
        end else if (sel_hdr) begin
            // Preamble: start symbol on the very first byte, SFD on the very last.
            if (k == 0) begin
                nxt_byte = W_BYTE'(8'hFB);
                nxt_ctrl = 1'b1;
            end else if (k == K_LAST) begin
                nxt_byte = W_BYTE'(8'hD5);
                nxt_ctrl = 1'b0;
            end else begin
                nxt_byte = W_BYTE'(8'h55);
                nxt_ctrl = 1'b0;
            end
        end else if (sel_data) begin
            nxt_byte = head_byte;
            nxt_ctrl = head_ctrl;
        end
    end
endmodule

module mac_tx_framegen #(
    parameter int                N_CHANNELS    = 4,
    parameter int                W_BYTE        = 8,
    parameter int                MAC_HDR_CNT   = 2,
    parameter int                W_MAC_HDR_CNT = 2,
    parameter logic [W_BYTE-1:0] SYM_IDLE      = 8'h07,
    parameter logic [W_BYTE-1:0] SYM_TERM      = 8'hFD,
    parameter logic [W_BYTE-1:0] SYM_ERROR     = 8'hFE
) (
    input  logic                           i_clk,
    input  logic                           i_reset,
    input  logic                           i_clk_en,
    input  logic [W_MAC_HDR_CNT-1:0]       i_hdr_id,
    input  logic                           i_gen_hdr,
    input  logic                           i_gen_data,
    input  logic                           i_gen_idle,
    input  logic                           i_gen_ifg,
    input  logic                           i_gen_error,
    input  logic                           i_buf_clear,
    input  logic                           i_buf_wen,
    input  logic                           i_buf_ren,
    input  logic [N_CHANNELS-1:0]          i_buf_wctrl,
    input  logic [N_CHANNELS*W_BYTE-1:0]   i_buf_wdata,
    output logic                           o_buf_empty,
    output logic                           o_buf_full,
    output logic [$clog2(8):0]             o_buf_level,
    output logic [N_CHANNELS*W_BYTE-1:0]   o_xgmii_data,
    output logic [N_CHANNELS-1:0]          o_xgmii_ctrl,
    output logic                           o_ovf_err,
    output logic                           o_udf_err,
    output logic [15:0]                    o_term_cnt
);
    localparam int BUF_DEPTH = 8;
    localparam int W_PTR     = $clog2(BUF_DEPTH);
    localparam int W_LVL     = W_PTR + 1;
    localparam int W_ENTRY   = N_CHANNELS + N_CHANNELS * W_BYTE;
    localparam int W_TC      = $clog2(N_CHANNELS + 1);

    logic [W_ENTRY-1:0] mem [BUF_DEPTH];
    logic [W_PTR-1:0]   wr_ptr, rd_ptr;
    logic [W_LVL-1:0]   level;

    logic [N_CHANNELS-1:0]             head_ctrl;
    logic [N_CHANNELS-1:0][W_BYTE-1:0] head_data;
    logic [N_CHANNELS-1:0][W_BYTE-1:0] nxt_data;
    logic [N_CHANNELS-1:0]             nxt_ctrl;
    logic [W_TC-1:0]                   term_hits;

    logic hdr_bad, sel_err, sel_hdr, sel_data, data_udf;
    logic push, pop, ovf, udf;

    assign o_buf_empty = (level == '0);
    assign o_buf_full  = (level == W_LVL'(BUF_DEPTH));
    assign o_buf_level = level;

    assign {head_ctrl, head_data} = mem[rd_ptr];

    // A data request on an empty buffer becomes an error word, never a stale read.
    assign hdr_bad  = int'(i_hdr_id) >= MAC_HDR_CNT;
    assign sel_err  = i_gen_error | (i_gen_hdr & hdr_bad) | data_udf;
    assign sel_hdr  = ~i_gen_error & i_gen_hdr & ~hdr_bad;
    assign data_udf = ~i_gen_error & ~i_gen_hdr & i_gen_data & o_buf_empty;
    assign sel_data = ~i_gen_error & ~i_gen_hdr & i_gen_data & ~o_buf_empty;

    // A full buffer still accepts a write when the same cycle frees a slot.
    assign push = ~i_buf_clear & i_buf_wen & (~o_buf_full | i_buf_ren);
    assign pop  = ~i_buf_clear & i_buf_ren & ~o_buf_empty;
    assign ovf  = ~i_buf_clear & i_buf_wen & o_buf_full & ~i_buf_ren;
    assign udf  = (~i_buf_clear & i_buf_ren & o_buf_empty) | data_udf;

    genvar gi;
    generate
        for (gi = 0; gi < N_CHANNELS; gi++) begin : g_lane
            mac_tx_lane #(
                .W_BYTE       (W_BYTE),
                .N_CHANNELS   (N_CHANNELS),
                .MAC_HDR_CNT  (MAC_HDR_CNT),
                .W_MAC_HDR_CNT(W_MAC_HDR_CNT),
                .LANE         (gi),
                .SYM_IDLE     (SYM_IDLE),
                .SYM_ERROR    (SYM_ERROR)
            ) u_lane (
                .sel_err  (sel_err),
                .sel_hdr  (sel_hdr),
                .sel_data (sel_data),
                .hdr_id   (i_hdr_id),
                .head_ctrl(head_ctrl[gi]),
                .head_byte(head_data[gi]),
                .nxt_byte (nxt_data[gi]),
                .nxt_ctrl (nxt_ctrl[gi])
            );
        end
    endgenerate

    always_comb begin
        term_hits = '0;
        for (int i = 0; i < N_CHANNELS; i++)
            term_hits = term_hits + W_TC'(nxt_ctrl[i] && (nxt_data[i] == SYM_TERM));
    end

    always_ff @(posedge i_clk) begin
        if (i_clk_en && push && !i_reset)
            mem[wr_ptr] <= {i_buf_wctrl, i_buf_wdata};
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            o_xgmii_data <= {N_CHANNELS{SYM_IDLE}};
            o_xgmii_ctrl <= '1;
            o_ovf_err    <= 1'b0;
            o_udf_err    <= 1'b0;
            o_term_cnt   <= '0;
        end else if (i_clk_en) begin
            if (i_buf_clear) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + 1'b1;
                if (pop)  rd_ptr <= rd_ptr + 1'b1;
                level <= level + W_LVL'(push) - W_LVL'(pop);
            end
            if (ovf) o_ovf_err <= 1'b1;
            if (udf) o_udf_err <= 1'b1;
            o_xgmii_data <= nxt_data;
            o_xgmii_ctrl <= nxt_ctrl;
            o_term_cnt   <= o_term_cnt + 16'(term_hits);
        end
    end
endmodule

// File: tb/tb_mac_tx_framegen.sv
// Directed bench for mac_tx_framegen: header, FIFO, termination, underflow,
// simultaneous access, clock enable and reset behaviour.

module tb_mac_tx_framegen;
    logic        i_clk = 1'b0;
    logic        i_reset, i_clk_en;
    logic [1:0]  i_hdr_id;
    logic        i_gen_hdr, i_gen_data, i_gen_idle, i_gen_ifg, i_gen_error;
    logic        i_buf_clear, i_buf_wen, i_buf_ren;
    logic [3:0]  i_buf_wctrl;
    logic [31:0] i_buf_wdata;
    logic        o_buf_empty, o_buf_full;
    logic [3:0]  o_buf_level;
    logic [31:0] o_xgmii_data;
    logic [3:0]  o_xgmii_ctrl;
    logic        o_ovf_err, o_udf_err;
    logic [15:0] o_term_cnt;

    int checks = 0;
    int errors = 0;

    mac_tx_framegen dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en), .i_hdr_id(i_hdr_id),
        .i_gen_hdr(i_gen_hdr), .i_gen_data(i_gen_data), .i_gen_idle(i_gen_idle),
        .i_gen_ifg(i_gen_ifg), .i_gen_error(i_gen_error), .i_buf_clear(i_buf_clear),
        .i_buf_wen(i_buf_wen), .i_buf_ren(i_buf_ren), .i_buf_wctrl(i_buf_wctrl),
        .i_buf_wdata(i_buf_wdata), .o_buf_empty(o_buf_empty), .o_buf_full(o_buf_full),
        .o_buf_level(o_buf_level), .o_xgmii_data(o_xgmii_data), .o_xgmii_ctrl(o_xgmii_ctrl),
        .o_ovf_err(o_ovf_err), .o_udf_err(o_udf_err), .o_term_cnt(o_term_cnt)
    );

    always #5 i_clk = ~i_clk;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        i_clk_en = 1'b1; i_hdr_id = '0;
        i_gen_hdr = 0; i_gen_data = 0; i_gen_idle = 0; i_gen_ifg = 0; i_gen_error = 0;
        i_buf_clear = 0; i_buf_wen = 0; i_buf_ren = 0;
        i_buf_wctrl = '0; i_buf_wdata = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_reset = 1'b1;
        step(); step();
        i_reset = 1'b0;
    endtask

    task automatic write_word(input logic [3:0] c, input logic [31:0] d);
        i_buf_wen = 1; i_buf_wctrl = c; i_buf_wdata = d;
        step();
        i_buf_wen = 0; i_buf_wctrl = '0; i_buf_wdata = '0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_buf_empty !== 1'b1 || o_buf_full !== 1'b0 || o_buf_level !== 4'd0) begin
            errors++; $display("FAIL reset_status: got e=%b f=%b l=%0d want 1 0 0", o_buf_empty, o_buf_full, o_buf_level); end
        checks++; if (o_xgmii_data !== 32'h07070707 || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL reset_out: got %h/%b want 07070707/1111", o_xgmii_data, o_xgmii_ctrl); end
        checks++; if (o_ovf_err !== 0 || o_udf_err !== 0 || o_term_cnt !== 16'd0) begin
            errors++; $display("FAIL reset_flags: got ovf=%b udf=%b term=%0d want 0 0 0", o_ovf_err, o_udf_err, o_term_cnt); end
    endtask

    task automatic test_header();
        do_reset();
        i_gen_hdr = 1; i_hdr_id = 2'd0; step();
        checks++; if (o_xgmii_data !== 32'h555555FB || o_xgmii_ctrl !== 4'b0001) begin
            errors++; $display("FAIL hdr0: got %h/%b want 555555FB/0001", o_xgmii_data, o_xgmii_ctrl); end
        i_hdr_id = 2'd1; step();
        checks++; if (o_xgmii_data !== 32'hD5555555 || o_xgmii_ctrl !== 4'b0000) begin
            errors++; $display("FAIL hdr1: got %h/%b want D5555555/0000", o_xgmii_data, o_xgmii_ctrl); end
        i_hdr_id = 2'd2; step();
        checks++; if (o_xgmii_data !== 32'hFEFEFEFE || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL hdr_bad_id: got %h/%b want FEFEFEFE/1111", o_xgmii_data, o_xgmii_ctrl); end
        i_hdr_id = 2'd0; i_gen_error = 1; step();
        checks++; if (o_xgmii_data !== 32'hFEFEFEFE || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL err_over_hdr: got %h/%b want FEFEFEFE/1111", o_xgmii_data, o_xgmii_ctrl); end
        i_gen_error = 0; i_gen_hdr = 0; i_gen_ifg = 1; step();
        checks++; if (o_xgmii_data !== 32'h07070707 || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL ifg_idle: got %h/%b want 07070707/1111", o_xgmii_data, o_xgmii_ctrl); end
        i_gen_ifg = 0;
    endtask

    task automatic test_fifo();
        logic [7:0] b;
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            write_word(4'b0000, {4{b}});
        end
        checks++; if (o_buf_full !== 1'b1 || o_buf_level !== 4'd8 || o_ovf_err !== 1'b0) begin
            errors++; $display("FAIL fifo_full: got f=%b l=%0d ovf=%b want 1 8 0", o_buf_full, o_buf_level, o_ovf_err); end
        write_word(4'b0000, 32'h09090909);
        checks++; if (o_ovf_err !== 1'b1 || o_buf_level !== 4'd8) begin
            errors++; $display("FAIL fifo_ovf: got ovf=%b l=%0d want 1 8", o_ovf_err, o_buf_level); end
        i_buf_ren = 1; i_gen_data = 1;
        for (int i = 1; i <= 8; i++) begin
            b = 8'(i);
            step();
            checks++; if (o_xgmii_data !== {4{b}} || o_xgmii_ctrl !== 4'b0000) begin
                errors++; $display("FAIL fifo_read%0d: got %h/%b want %h/0000", i, o_xgmii_data, o_xgmii_ctrl, {4{b}}); end
        end
        i_buf_ren = 0; i_gen_data = 0;
        checks++; if (o_buf_empty !== 1'b1 || o_buf_level !== 4'd0 || o_udf_err !== 1'b0) begin
            errors++; $display("FAIL fifo_drained: got e=%b l=%0d udf=%b want 1 0 0", o_buf_empty, o_buf_level, o_udf_err); end
    endtask

    task automatic test_term();
        do_reset();
        write_word(4'b1100, 32'h07FD3322);
        i_buf_ren = 1; i_gen_data = 1; step();
        i_buf_ren = 0; i_gen_data = 0;
        checks++; if (o_xgmii_data !== 32'h07FD3322 || o_xgmii_ctrl !== 4'b1100) begin
            errors++; $display("FAIL term_word: got %h/%b want 07FD3322/1100", o_xgmii_data, o_xgmii_ctrl); end
        checks++; if (o_term_cnt !== 16'd1) begin
            errors++; $display("FAIL term_cnt: got %0d want 1", o_term_cnt); end
        step();
        checks++; if (o_term_cnt !== 16'd1) begin
            errors++; $display("FAIL term_cnt_hold: got %0d want 1", o_term_cnt); end
    endtask

    task automatic test_underflow();
        do_reset();
        i_buf_ren = 1; i_gen_data = 1; step();
        i_buf_ren = 0; i_gen_data = 0;
        checks++; if (o_xgmii_data !== 32'hFEFEFEFE || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL udf_word: got %h/%b want FEFEFEFE/1111", o_xgmii_data, o_xgmii_ctrl); end
        checks++; if (o_udf_err !== 1'b1 || o_buf_level !== 4'd0) begin
            errors++; $display("FAIL udf_flag: got udf=%b l=%0d want 1 0", o_udf_err, o_buf_level); end
        step(); step();
        checks++; if (o_udf_err !== 1'b1) begin
            errors++; $display("FAIL udf_sticky: got %b want 1", o_udf_err); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 0; i < 8; i++) write_word(4'b0000, 32'hA0A0A0A0 + 32'(i));
        i_buf_wen = 1; i_buf_ren = 1; i_buf_wdata = 32'h11111111; step();
        checks++; if (o_buf_level !== 4'd8 || o_ovf_err !== 1'b0 || o_buf_full !== 1'b1) begin
            errors++; $display("FAIL sim_full: got l=%0d ovf=%b f=%b want 8 0 1", o_buf_level, o_ovf_err, o_buf_full); end
        i_buf_clear = 1; step();
        i_buf_clear = 0;
        checks++; if (o_buf_level !== 4'd0 || o_buf_empty !== 1'b1 || o_ovf_err !== 1'b0 || o_udf_err !== 1'b0) begin
            errors++; $display("FAIL sim_clear: got l=%0d e=%b ovf=%b udf=%b want 0 1 0 0", o_buf_level, o_buf_empty, o_ovf_err, o_udf_err); end
        // Empty: write accepted, read underflows, no bypass of the new word.
        i_gen_data = 1; step();
        i_buf_wen = 0; i_buf_ren = 0; i_gen_data = 0;
        checks++; if (o_buf_level !== 4'd1 || o_udf_err !== 1'b1) begin
            errors++; $display("FAIL sim_empty: got l=%0d udf=%b want 1 1", o_buf_level, o_udf_err); end
        checks++; if (o_xgmii_data !== 32'hFEFEFEFE || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL sim_no_bypass: got %h/%b want FEFEFEFE/1111", o_xgmii_data, o_xgmii_ctrl); end
    endtask

    task automatic test_clk_en();
        do_reset();
        write_word(4'b0000, 32'hAAAAAAAA);
        write_word(4'b0000, 32'hBBBBBBBB);
        i_gen_hdr = 1; i_hdr_id = 2'd0; step();
        i_gen_hdr = 0;
        i_clk_en = 0;
        for (int i = 0; i < 3; i++) begin
            i_buf_wen = (i != 1); i_buf_ren = (i != 0); i_gen_error = (i == 1);
            i_buf_clear = (i == 2); i_gen_data = 1;
            step();
        end
        idle_inputs();
        checks++; if (o_buf_level !== 4'd2 || o_xgmii_data !== 32'h555555FB || o_xgmii_ctrl !== 4'b0001) begin
            errors++; $display("FAIL clken_hold: got l=%0d %h/%b want 2 555555FB/0001", o_buf_level, o_xgmii_data, o_xgmii_ctrl); end
        checks++; if (o_ovf_err !== 0 || o_udf_err !== 0 || o_term_cnt !== 16'd0) begin
            errors++; $display("FAIL clken_flags: got ovf=%b udf=%b term=%0d want 0 0 0", o_ovf_err, o_udf_err, o_term_cnt); end
        i_buf_ren = 1; i_gen_data = 1; step();
        checks++; if (o_xgmii_data !== 32'hAAAAAAAA || o_buf_level !== 4'd1) begin
            errors++; $display("FAIL clken_resume: got %h l=%0d want AAAAAAAA 1", o_xgmii_data, o_buf_level); end
        step(); step();
        checks++; if (o_udf_err !== 1'b1) begin
            errors++; $display("FAIL clken_udf: got %b want 1", o_udf_err); end
        write_word(4'b1111, 32'hCCCCCCCC);
        idle_inputs();
        i_clk_en = 0; i_reset = 1; i_gen_hdr = 1; step();
        i_reset = 0; i_clk_en = 1; i_gen_hdr = 0;
        checks++; if (o_xgmii_data !== 32'h07070707 || o_xgmii_ctrl !== 4'hF || o_buf_level !== 4'd0) begin
            errors++; $display("FAIL midrst_out: got %h/%b l=%0d want 07070707/1111 0", o_xgmii_data, o_xgmii_ctrl, o_buf_level); end
        checks++; if (o_udf_err !== 0 || o_ovf_err !== 0 || o_buf_empty !== 1'b1) begin
            errors++; $display("FAIL midrst_flags: got udf=%b ovf=%b e=%b want 0 0 1", o_udf_err, o_ovf_err, o_buf_empty); end
        step();
        checks++; if (o_xgmii_data !== 32'h07070707 || o_xgmii_ctrl !== 4'hF) begin
            errors++; $display("FAIL postrst_idle: got %h/%b want 07070707/1111", o_xgmii_data, o_xgmii_ctrl); end
    endtask

    initial begin
        idle_inputs();
        i_reset = 1'b1;
        test_reset();
        test_header();
        test_fifo();
        test_term();
        test_underflow();
        test_simultaneous();
        test_clk_en();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
